// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor
//   Watches the one-hot phase vector of an upstream 4-bit ring counter. It
//   reports the index of the hot bit, locks onto the rotation
//   1000 -> 0100 -> 0010 -> 0001 -> 1000, counts completed rotations while
//   locked, and latches the first fault it sees until software clears it.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset, overrides every input
//   phase[3:0] in   one-hot phase from the ring counter
//   clr_err    in   clears a latched fault (only acted on in FAULT)
//   slot[1:0]  out  registered index of the hot phase bit (holds if not one-hot)
//   slot_valid out  registered, 1 when the sampled phase was one-hot
//   lock       out  1 while in LOCKED
//   rot_cnt    out  completed rotations while locked, wraps 255 -> 0
//   rot_wrap   out  one-cycle pulse on the rot_cnt wrap
//   err        out  sticky fault flag
//   err_code   out  00 none, 01 not one-hot, 10 out-of-order, 11 stall
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for any one-hot phase
// SYNC   | counting consecutive legal transitions (3 needed to lock)
// LOCKED | rotation verified; counting rotations, any deviation faults
// FAULT  | fault latched, waits for clr_err

module ring_phase_monitor (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] phase,
    input  logic       clr_err,
    output logic [1:0] slot,
    output logic       slot_valid,
    output logic       lock,
    output logic [7:0] rot_cnt,
    output logic       rot_wrap,
    output logic       err,
    output logic [1:0] err_code
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SYNC   = 2'd1,
        S_LOCKED = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] prev;
    logic [1:0] good_cnt, good_nxt;
    logic       err_nxt;
    logic [1:0] code_nxt;
    logic       rot_inc;
    logic       phase_oh;
    logic [3:0] expected;
    logic [1:0] slot_enc;

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    assign phase_oh = (phase != 4'b0000) && ((phase & (phase - 4'd1)) == 4'b0000);
    assign expected = {prev[0], prev[3:1]};
    assign lock     = (state == S_LOCKED);

    always_comb begin
        slot_enc = 2'd0;
        case (phase)
            4'b1000: slot_enc = 2'd3;
            4'b0100: slot_enc = 2'd2;
            4'b0010: slot_enc = 2'd1;
            default: slot_enc = 2'd0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        err_nxt   = err;
        code_nxt  = err_code;
        rot_inc   = 1'b0;
        case (state)
            S_IDLE: begin
                if (phase_oh) begin
                    state_nxt = S_SYNC;
                    good_nxt  = 2'd0;
                end
            end
            S_SYNC: begin
                if (!phase_oh) begin
                    state_nxt = S_IDLE;
                    good_nxt  = 2'd0;
                end else if (phase == expected) begin
                    if (good_cnt == 2'd2) begin
                        state_nxt = S_LOCKED;
                        good_nxt  = 2'd0;
                    end else begin
                        good_nxt = good_cnt + 2'd1;
                    end
                end else begin
                    good_nxt = 2'd0;
                end
            end
            S_LOCKED: begin
                if (phase == expected) begin
                    // legal step out of 0001 is necessarily into 1000
                    rot_inc = (prev == 4'b0001);
                end else begin
                    state_nxt = S_FAULT;
                    err_nxt   = 1'b1;
                    if (!phase_oh)
                        code_nxt = 2'b01;
                    else if (phase == prev)
                        code_nxt = 2'b11;
                    else
                        code_nxt = 2'b10;
                end
            end
            S_FAULT: begin
                if (clr_err) begin
                    state_nxt = S_IDLE;
                    err_nxt   = 1'b0;
                    code_nxt  = 2'b00;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            prev       <= 4'b0000;
            good_cnt   <= 2'd0;
            slot       <= 2'd0;
            slot_valid <= 1'b0;
            rot_cnt    <= 8'd0;
            rot_wrap   <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            state      <= state_nxt;
            prev       <= phase;
            good_cnt   <= good_nxt;
            err        <= err_nxt;
            err_code   <= code_nxt;
            slot_valid <= phase_oh;
            if (phase_oh)
                slot <= slot_enc;
            if (rot_inc) begin
                rot_cnt  <= rot_cnt + 8'd1;
                rot_wrap <= (rot_cnt == 8'hFF);
            end else begin
                rot_wrap <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ring_phase_monitor.sv
module tb_ring_phase_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] phase = 4'b0000;
    logic       clr_err = 1'b0;
    logic [1:0] slot;
    logic       slot_valid;
    logic       lock;
    logic [7:0] rot_cnt;
    logic       rot_wrap;
    logic       err;
    logic [1:0] err_code;

    ring_phase_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .phase      (phase),
        .clr_err    (clr_err),
        .slot       (slot),
        .slot_valid (slot_valid),
        .lock       (lock),
        .rot_cnt    (rot_cnt),
        .rot_wrap   (rot_wrap),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] slot;
        logic       sv;
        logic       lock;
        logic [7:0] rc;
        logic       rw;
        logic       err;
        logic [1:0] ec;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model: monitor mode as plain integers
    localparam int M_IDLE = 0, M_SYNC = 1, M_LOCK = 2, M_FAULT = 3;
    int         m_mode = M_IDLE;
    int         m_good = 0;
    logic [3:0] m_prev = 4'b0000;
    exp_t       m;
    logic [3:0] ph = 4'b0000;

    function automatic int hot_idx(input logic [3:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < 4; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [3:0] p, input logic c);
        int  pi, ci;
        bit  oh, legal;
        if (r) begin
            m_mode = M_IDLE; m_good = 0; m_prev = 4'b0000;
            m = '0;
            return;
        end
        ci    = hot_idx(p);
        pi    = hot_idx(m_prev);
        oh    = (ci >= 0);
        legal = oh && (pi >= 0) && (ci == (pi + 3) % 4);
        m.rw  = 1'b0;
        case (m_mode)
            M_IDLE: if (oh) begin m_mode = M_SYNC; m_good = 0; end
            M_SYNC: begin
                if (!oh) m_mode = M_IDLE;
                else if (legal) begin
                    m_good++;
                    if (m_good == 3) begin m_mode = M_LOCK; m_good = 0; end
                end else m_good = 0;
            end
            M_LOCK: begin
                if (legal) begin
                    if (pi == 0) begin
                        m.rw = (m.rc == 8'd255);
                        m.rc = 8'((int'(m.rc) + 1) % 256);
                    end
                end else begin
                    m_mode = M_FAULT;
                    m.err  = 1'b1;
                    m.ec   = !oh ? 2'b01 : (p == m_prev) ? 2'b11 : 2'b10;
                end
            end
            default: if (c) begin m_mode = M_IDLE; m.err = 1'b0; m.ec = 2'b00; end
        endcase
        if (oh) begin m.slot = 2'(ci); m.sv = 1'b1; end
        else m.sv = 1'b0;
        m.lock = (m_mode == M_LOCK);
        m_prev = p;
    endtask

    task automatic drive(input logic r, input logic [3:0] p, input logic c);
        @(negedge clk);
        rst = r; phase = p; clr_err = c;
        ph = p;
        model_step(r, p, c);
        sb.push_back(m);
    endtask

    function automatic logic [3:0] nxt(input logic [3:0] p);
        if ($countones(p) != 1) return 4'b1000;
        return {p[0], p[3:1]};
    endfunction

    task automatic legal_steps(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, nxt(ph), 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b1, 4'b0000, 1'b0);
    endtask

    task automatic lock_up();
        drive(1'b0, 4'b1000, 1'b0);
        legal_steps(3);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("slot",       int'(slot),       int'(e.slot));
            chk("slot_valid", int'(slot_valid), int'(e.sv));
            chk("lock",       int'(lock),       int'(e.lock));
            chk("rot_cnt",    int'(rot_cnt),    int'(e.rc));
            chk("rot_wrap",   int'(rot_wrap),   int'(e.rw));
            chk("err",        int'(err),        int'(e.err));
            chk("err_code",   int'(err_code),   int'(e.ec));
        end
    end

    initial begin
        logic [3:0] inj [4];
        int r;
        do_reset();
        do_reset();

        // lock-up and 10 rotations
        lock_up();
        legal_steps(40);

        // fault types, each followed by sticky hold, clear and relock
        for (int k = 0; k < 4; k++) begin
            do_reset();
            lock_up();
            legal_steps(2);              // ... 1000, 0100
            inj[0] = 4'b0000; inj[1] = 4'b0100; inj[2] = 4'b0001; inj[3] = 4'b1000;
            drive(1'b0, inj[k], 1'b0);
            legal_steps(20);
            drive(1'b0, nxt(ph), 1'b1);
            legal_steps(6);
        end

        // reset priority over clr_err in FAULT with rot_cnt = 5
        do_reset();
        lock_up();
        legal_steps(20);
        drive(1'b0, 4'b0000, 1'b0);
        drive(1'b1, 4'b1000, 1'b1);
        drive(1'b0, 4'b0000, 1'b0);

        // sync robustness
        do_reset();
        drive(1'b0, 4'b1000, 1'b0);
        drive(1'b0, 4'b0100, 1'b0);
        drive(1'b0, 4'b1000, 1'b0);
        legal_steps(6);

        // 256 rotations -> wrap
        do_reset();
        lock_up();
        legal_steps(1030);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 1)       drive(1'b1, nxt(ph), 1'b0);
            else if (r < 85) drive(1'b0, nxt(ph), ($urandom_range(0, 29) == 0));
            else if (r < 93) drive(1'b0, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
            else if (r < 97) drive(1'b0, ph, 1'b0);
            else             drive(1'b0, {ph[2:0], ph[3]}, 1'b0);
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected responses never compared, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_phase_monitor.md
RING_PHASE_MONITOR -- requirements
Module: ring_phase_monitor

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port phase, input, 4 bits: one-hot phase vector from the upstream 4-bit ring counter; the legal sequence is 1000->0100->0010->0001->1000.
REQ-004 SHALL have port clr_err, input, 1 bit: clears a latched fault; sampled on the rising clk edge.
REQ-005 SHALL have port slot, output, 2 bits: binary index of the hot bit of phase (bit3=3 ... bit0=0), registered.
REQ-006 SHALL have port slot_valid, output, 1 bit: registered; 1 when the sampled phase was one-hot.
REQ-007 SHALL have port lock, output, 1 bit: 1 while the FSM is in LOCKED.
REQ-008 SHALL have port rot_cnt, output, 8 bits: count of completed rotations.
REQ-009 SHALL have port rot_wrap, output, 1 bit: one-cycle pulse when rot_cnt wraps from 255 to 0.
REQ-010 SHALL have port err, output, 1 bit: sticky fault flag.
REQ-011 SHALL have port err_code, output, 2 bits: 00=none, 01=not one-hot, 10=out-of-order, 11=stall.

Function
REQ-012 SHALL register phase into prev each cycle; expected next value = {prev[0], prev[3:1]}.
REQ-013 SHALL update slot/slot_valid 1 cycle after phase is sampled; when phase is not one-hot, slot SHALL hold its last value and slot_valid SHALL be 0.
REQ-014 SHALL implement FSM states IDLE, SYNC, LOCKED, FAULT.
REQ-015 IDLE: one-hot phase -> SYNC with good_cnt=0; otherwise stay in IDLE.
REQ-016 SYNC: phase == expected -> good_cnt+1; on the 3rd consecutive good transition -> LOCKED; one-hot but unexpected -> stay in SYNC, good_cnt=0; not one-hot -> IDLE.
REQ-017 LOCKED: phase == expected -> stay; any other value -> FAULT, with err=1 and err_code set on the same edge.
REQ-018 Fault classification priority SHALL be: not one-hot (01) > stall, phase==prev (11) > out-of-order (10).
REQ-019 FAULT: err and err_code SHALL hold regardless of phase until clr_err=1; clr_err in FAULT -> IDLE, and err, err_code, lock -> 0 on that edge.
REQ-020 SHALL ignore clr_err in every state other than FAULT.
REQ-021 SHALL increment rot_cnt only in LOCKED, on the edge where prev==0001 and phase==1000.
REQ-022 rot_cnt SHALL wrap 255->0 and pulse rot_wrap for exactly that cycle; rot_cnt SHALL hold in all other states and SHALL NOT be cleared by clr_err.
REQ-023 lock SHALL be 1 exactly while the state is LOCKED, driven from registered state.
REQ-024 SHALL follow only the fixed rotation direction 1000->0100->0010->0001; the reverse direction SHALL be treated as out-of-order.

Reset
REQ-025 rst SHALL take priority over all inputs, including clr_err.
REQ-026 On rst: state=IDLE, prev=0000, good_cnt=0, slot=00, slot_valid=0, lock=0, rot_cnt=0, rot_wrap=0, err=0, err_code=00.
REQ-027 rst asserted mid-rotation or in FAULT SHALL give the REQ-026 values on the next edge; lock SHALL need a fresh sync after rst.

Verification
REQ-028 Lock-up: rst 1 cycle, then phase follows the legal sequence from 1000 -> lock=1 on the edge sampling the 4th legal value; slot follows 3,2,1,0 with 1-cycle lag.
REQ-029 Rotation count: 10 full rotations while LOCKED -> rot_cnt=10; at 256 rotations -> rot_cnt=0 and rot_wrap high for exactly 1 cycle.
REQ-030 Fault types: while LOCKED, inject 0000 -> err=1, err_code=01; separate runs: repeat 0100 -> err_code=11; 0100->0001 -> err_code=10; 0100->1000 (reverse) -> err_code=10.
REQ-031 Sticky fault: after a fault, drive legal phase for 20 cycles -> err stays 1 and lock stays 0; then clr_err=1 -> err=0, state IDLE, relock after 3 good transitions.
REQ-032 Reset priority: rst=1 and clr_err=1 together in FAULT with rot_cnt=5 -> all outputs equal REQ-026 values, rot_cnt=0.
REQ-033 Sync robustness: in SYNC, feed 1000,0100,1000 -> no lock and no err; then a clean sequence -> lock after 3 good transitions.
